// File: rtl/hot_vector_decoder_13bit.sv
// Purpose: decodes a stream of index beats into one-hot bits and ORs them into a frame vector.
// Latency: hot_valid_o rises one cycle after the beat flagged last is accepted.
// Backpressure: while a frame is held, idx_ready_o is low and upstream beats wait; no double buffering.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), synchronous active-high reset
//   idx_i/idx_valid_i/idx_last_i/idx_ready_o   index beat stream (valid/ready)
//   hot_vector_o/hot_valid_o/hot_ready_i       assembled frame (valid/ready)
//   beat_cnt_o             accepted beats in the current or held frame, saturating
//   dup_o, err_o           sticky per-frame repeated-index / out-of-range flags
module hot_vector_decoder_13bit #(
  parameter int WIDTH = 13,
  parameter int IDX_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               idx_valid_i,
  input  logic               idx_last_i,
  output logic               idx_ready_o,
  output logic [WIDTH-1:0]   hot_vector_o,
  output logic               hot_valid_o,
  input  logic               hot_ready_i,
  output logic [IDX_W:0]     beat_cnt_o,
  output logic               dup_o,
  output logic               err_o
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [IDX_W:0] CNT_MAX = '1;
  localparam int unsigned    WIDTH_U = WIDTH;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [IDX_W:0]   beat_cnt;
  logic             dup;
  logic             err;
  logic             ready_q;
  logic             valid_q;

  logic [WIDTH-1:0] onehot;
  logic             in_range;
  logic             beat_acc;
  logic             frame_taken;

  // Shifting past the top bit yields zero, so out-of-range indices decode to
  // an empty mask; in_range still gates the update so err is flagged instead.
  assign onehot      = WIDTH'(1) << idx_i;
  assign in_range    = (32'(idx_i) < WIDTH_U);
  assign beat_acc    = idx_valid_i && ready_q;
  assign frame_taken = valid_q && hot_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ACCUM;
      acc      <= '0;
      beat_cnt <= '0;
      dup      <= 1'b0;
      err      <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat_acc) begin
            if (in_range) begin
              acc <= acc | onehot;
              if ((acc & onehot) != '0) begin
                dup <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
            if (beat_cnt != CNT_MAX) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            // The last beat's own update lands on the same edge as the move
            // to HOLD, so the held frame already includes it.
            if (idx_last_i) begin
              state   <= HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_taken) begin
            state    <= ACCUM;
            acc      <= '0;
            beat_cnt <= '0;
            dup      <= 1'b0;
            err      <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
          end
        end
        default: begin
          state   <= ACCUM;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign idx_ready_o  = ready_q;
  assign hot_valid_o  = valid_q;
  assign hot_vector_o = acc;
  assign beat_cnt_o   = beat_cnt;
  assign dup_o        = dup;
  assign err_o        = err;

endmodule

// File: tb/tb_hot_vector_decoder_13bit.sv
module tb_hot_vector_decoder_13bit;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  idx_i;
  logic        idx_valid_i;
  logic        idx_last_i;
  logic        idx_ready_o;
  logic [12:0] hot_vector_o;
  logic        hot_valid_o;
  logic        hot_ready_i;
  logic [4:0]  beat_cnt_o;
  logic        dup_o;
  logic        err_o;

  int tests;
  int failed;

  hot_vector_decoder_13bit #(.WIDTH(13), .IDX_W(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .idx_i        (idx_i),
    .idx_valid_i  (idx_valid_i),
    .idx_last_i   (idx_last_i),
    .idx_ready_o  (idx_ready_o),
    .hot_vector_o (hot_vector_o),
    .hot_valid_o  (hot_valid_o),
    .hot_ready_i  (hot_ready_i),
    .beat_cnt_o   (beat_cnt_o),
    .dup_o        (dup_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] idx, input logic last);
    int  n;
    logic took;
    idx_i       = idx;
    idx_last_i  = last;
    idx_valid_i = 1'b1;
    n = 0;
    took = 1'b0;
    while (!took && n < 200) begin
      took = idx_ready_o;
      tick();
      n++;
    end
    idx_valid_i = 1'b0;
    idx_last_i  = 1'b0;
    if (!took) check("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!hot_valid_o && n < 50) begin
      tick();
      n++;
    end
    if (!hot_valid_o) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_frame();
    hot_ready_i = 1'b1;
    tick();
    hot_ready_i = 1'b0;
    check("taken_valid", 32'(hot_valid_o), 32'd0);
    check("taken_ready", 32'(idx_ready_o), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(idx_ready_o), 32'd1);
    check({tag, "_valid"}, 32'(hot_valid_o), 32'd0);
    check({tag, "_vec"},   32'(hot_vector_o), 32'd0);
    check({tag, "_cnt"},   32'(beat_cnt_o), 32'd0);
    check({tag, "_dup"},   32'(dup_o), 32'd0);
    check({tag, "_err"},   32'(err_o), 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [12:0] vec, input logic [4:0] cnt,
                             input logic dup, input logic err);
    check({tag, "_valid"}, 32'(hot_valid_o), 32'd1);
    check({tag, "_ready"}, 32'(idx_ready_o), 32'd0);
    check({tag, "_vec"},   32'(hot_vector_o), 32'(vec));
    check({tag, "_cnt"},   32'(beat_cnt_o), 32'(cnt));
    check({tag, "_dup"},   32'(dup_o), 32'(dup));
    check({tag, "_err"},   32'(err_o), 32'(err));
  endtask

  function automatic int lowest_set(input logic [12:0] v);
    for (int i = 0; i < 13; i++) begin
      if (v[i]) return i;
    end
    return 13;
  endfunction

  initial begin
    logic [12:0] v;
    int          order[13];
    int          nbits;
    int          j;
    int          tmp;

    tests = 0;
    failed = 0;
    rst_i = 1'b1;
    idx_i = 4'd0;
    idx_valid_i = 1'b0;
    idx_last_i = 1'b0;
    hot_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    check_reset("rst");

    // 1: single beat frame
    send_beat(4'd5, 1'b1);
    check_frame("t1", 13'h0020, 5'd1, 1'b0, 1'b0);
    take_frame();

    // 2: held frame under stall, extra beat waits and is not lost
    send_beat(4'd0, 1'b0);
    send_beat(4'd12, 1'b0);
    send_beat(4'd7, 1'b1);
    check_frame("t2", 13'h1081, 5'd3, 1'b0, 1'b0);
    idx_i = 4'd3;
    idx_last_i = 1'b1;
    idx_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_hold_vec", 32'(hot_vector_o), 32'h1081);
      check("t2_hold_ready", 32'(idx_ready_o), 32'd0);
      check("t2_hold_cnt", 32'(beat_cnt_o), 32'd3);
    end
    hot_ready_i = 1'b1;
    tick();
    hot_ready_i = 1'b0;
    check("t2_taken_valid", 32'(hot_valid_o), 32'd0);
    check("t2_taken_vec", 32'(hot_vector_o), 32'd0);
    check("t2_taken_ready", 32'(idx_ready_o), 32'd1);
    tick();
    idx_valid_i = 1'b0;
    idx_last_i = 1'b0;
    check_frame("t2_held_beat", 13'h0008, 5'd1, 1'b0, 1'b0);
    take_frame();

    // 3: duplicate index, flag does not leak into the next frame
    send_beat(4'd3, 1'b0);
    send_beat(4'd3, 1'b0);
    send_beat(4'd9, 1'b1);
    check_frame("t3", 13'h0208, 5'd3, 1'b1, 1'b0);
    take_frame();
    send_beat(4'd1, 1'b1);
    check_frame("t3_next", 13'h0002, 5'd1, 1'b0, 1'b0);
    take_frame();

    // 4: out-of-range indices
    send_beat(4'd14, 1'b0);
    send_beat(4'd2, 1'b1);
    check_frame("t4", 13'h0004, 5'd2, 1'b0, 1'b1);
    take_frame();
    send_beat(4'd15, 1'b1);
    check_frame("t4_only_oor", 13'h0000, 5'd1, 1'b0, 1'b1);
    take_frame();

    // 5: reset mid-frame discards the partial frame
    send_beat(4'd4, 1'b0);
    send_beat(4'd6, 1'b0);
    check("t5_mirror_vec", 32'(hot_vector_o), 32'h0050);
    check("t5_mirror_cnt", 32'(beat_cnt_o), 32'd2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset("t5_rst");
    send_beat(4'd8, 1'b1);
    check_frame("t5", 13'h0100, 5'd1, 1'b0, 1'b0);

    // reset while a frame is held
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset("hold_rst");

    // saturation: 33 beats all on bit 0
    for (int k = 0; k < 33; k++) begin
      send_beat(4'd0, (k == 32) ? 1'b1 : 1'b0);
    end
    check_frame("sat", 13'h0001, 5'd31, 1'b1, 1'b0);
    take_frame();

    // 6: random round-trip frames with gaps and stalls
    for (int f = 0; f < 1000; f++) begin
      v = 13'($urandom_range(1, 8191));
      nbits = 0;
      for (int b = 0; b < 13; b++) begin
        if (v[b]) begin
          order[nbits] = b;
          nbits++;
        end
      end
      for (int b = nbits - 1; b > 0; b--) begin
        j = $urandom_range(0, b);
        tmp = order[b];
        order[b] = order[j];
        order[j] = tmp;
      end
      for (int b = 0; b < nbits; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          idx_i = 4'($urandom_range(0, 15));
          tick();
        end
        send_beat(4'(order[b]), (b == nbits - 1) ? 1'b1 : 1'b0);
      end
      wait_valid();
      for (int s = $urandom_range(0, 2); s > 0; s--) tick();
      check("rnd_vec", 32'(hot_vector_o), 32'(v));
      check("rnd_cnt", 32'(beat_cnt_o), 32'(nbits));
      check("rnd_pe_idx", 32'(lowest_set(hot_vector_o)), 32'(order_min(v)));
      check("rnd_pe_valid", 32'(hot_vector_o != 13'd0), 32'd1);
      hot_ready_i = 1'b1;
      tick();
      hot_ready_i = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Independent lowest-index reference: scans downward, keeping the last hit.
  function automatic int order_min(input logic [12:0] v);
    int m;
    m = 13;
    for (int i = 12; i >= 0; i--) begin
      if (v[i]) m = i;
    end
    return m;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hot_vector_decoder_13bit.md
Name: hot_vector_decoder_13bit

Overview:
Inverse of the 13-bit priority encoder. Accepts a stream of index beats (idx, last) on a valid/ready handshake and decodes each index to one-hot. ORs the one-hot values into a 13-bit accumulator and emits the completed hot vector as one output frame on a valid/ready handshake. Rebuilds the request/hit vectors that the encoder side serialized as indices.

Parameters:
WIDTH, 13, number of vector bits; legal index range 0..WIDTH-1
IDX_W, 4, index width; must satisfy 2**IDX_W >= WIDTH

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
idx_i  input  IDX_W  index beat
idx_valid_i  input  1  index beat valid
idx_last_i  input  1  final beat of the current frame
idx_ready_o  output  1  decoder can accept a beat
hot_vector_o  output  WIDTH  assembled hot vector
hot_valid_o  output  1  hot_vector_o holds a complete frame
hot_ready_i  input  1  downstream accepts the frame
beat_cnt_o  output  IDX_W+1  accepted beats in the current or held frame, saturating
dup_o  output  1  frame contained a repeated index (sticky per frame)
err_o  output  1  frame contained an out-of-range index (sticky per frame)

Behaviour:
- Single clock domain. Synchronous active-high reset. All outputs are registered.
- Reset values:
  - idx_ready_o=1, hot_valid_o=0, hot_vector_o=0, beat_cnt_o=0, dup_o=0, err_o=0.
  - FSM enters ACCUM.
- Beat accepted when idx_valid_i && idx_ready_o on a rising edge.
- FSM state ACCUM:
  - idx_ready_o=1, hot_valid_o=0.
  - Accepted beat with idx_i < WIDTH: acc <= acc | (1<<idx_i).
  - If that bit was already set in acc, dup <= 1.
  - Accepted beat with idx_i >= WIDTH (13..15): acc is unchanged, err <= 1.
  - beat_cnt increments by 1 per accepted beat and saturates at 2**(IDX_W+1)-1.
  - Accepted beat with idx_last_i=1: the same edge applies the beat's update and moves to HOLD.
  - On that edge, hot_vector_o, dup_o, err_o and beat_cnt_o register the final values, including the last beat.
  - Latency: hot_valid_o rises one cycle after the last beat is accepted.
- FSM state HOLD:
  - idx_ready_o=0, hot_valid_o=1.
  - hot_vector_o, beat_cnt_o, dup_o and err_o stay stable until the frame is taken.
  - Frame taken when hot_valid_o && hot_ready_i on a rising edge. On that edge:
    - acc, dup, err and beat_cnt clear to 0.
    - FSM returns to ACCUM; next cycle idx_ready_o=1, hot_valid_o=0.
  - Max throughput is one frame per (beats + 1) cycles; no double buffering.
- hot_vector_o, dup_o, err_o and beat_cnt_o outside HOLD:
  - In ACCUM they mirror the running accumulator state, one cycle after each beat.
  - Consumers sample them only while hot_valid_o=1.
- Frame containing only out-of-range beats: completes normally with hot_vector_o=0, err_o=1, hot_valid_o=1.
- Frame where every beat is a duplicate of bit 0: vector 13'h0001, dup_o=1.
- idx_valid_i with idx_ready_o=0: ignored. The upstream source holds the beat; it is not lost.
- Reset mid-frame or during HOLD:
  - Partial or held frame is discarded; no output handshake occurs.
  - All state returns to reset values on the next edge.
- X or undefined idx_i while idx_valid_i=0: no effect.
- Round-trip property: for any nonzero vector V, feeding the decoder the beats of V's set bits (any order, last on the final beat) yields hot_vector_o == V. The priority encoder applied to hot_vector_o returns the lowest set index.

Test Plan:
1. Reset, then single beat idx=5, last=1 -> next cycle hot_valid_o=1, hot_vector_o=13'h0020, beat_cnt_o=1, dup_o=0, err_o=0; with hot_ready_i=1, ACCUM and idx_ready_o=1 one cycle later.
2. Beats 0,12,7 (last on 7), hot_ready_i=0 for 5 cycles -> hot_vector_o=13'h1081 held stable, idx_ready_o=0 throughout, extra idx_valid_i beats not consumed; release ready -> frame accepted once.
3. Beats 3,3,9 (last) -> hot_vector_o=13'h0208, beat_cnt_o=3, dup_o=1; the next frame (beat 1, last) shows dup_o=0, vector 13'h0002.
4. Beats 14, 2 (last) -> hot_vector_o=13'h0004, err_o=1, beat_cnt_o=2; frame of beat 15 only -> vector 0, err_o=1, hot_valid_o=1.
5. Beats 4,6 (no last), assert rst_i one cycle -> all outputs at reset values; then beat 8 with last -> vector 13'h0100 only.
6. Random 1000 frames: random nonzero 13-bit V, beats in random order with random valid gaps and ready stalls -> hot_vector_o==V every frame; the priority encoder on the output gives the lowest set index, valid=1.
